// File: rtl/avl_onchip_ram_pkg.sv
// Shared types and constants for the Avalon-MM on-chip RAM slave.
// Provides the FSM state type, the legal read latencies and the byte-lane helper.
package avl_onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int unsigned RD_LAT_ONE = 1;
  localparam int unsigned RD_LAT_TWO = 2;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/avl_onchip_ram_if.sv
// Avalon-MM pipelined slave bus bundle, including the clock enable and the clear-busy status.
interface avl_onchip_ram_if
  import avl_onchip_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] address;
  logic [LANES-1:0]      byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;
  logic                  clear_busy;

  modport master (
    output address, byteenable, chipselect, read, write, writedata, clken,
    input  readdata, readdatavalid, waitrequest, clear_busy
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata, clken,
    output readdata, readdatavalid, waitrequest, clear_busy
  );

endinterface

// File: rtl/avl_onchip_ram_core.sv
// Inferred single-port RAM: byte-enabled write, synchronous read, all activity gated by clken.
module avl_onchip_ram_core
  import avl_onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 5120
) (
  input  logic                                clk,
  input  logic                                i_clken,
  input  logic                                i_we,
  input  logic [lane_count(DATA_WIDTH)-1:0]   i_be,
  input  logic [$clog2(DEPTH)-1:0]            i_addr,
  input  logic [DATA_WIDTH-1:0]               i_wdata,
  output logic [DATA_WIDTH-1:0]               o_rdata
);
  localparam int unsigned LANES = lane_count(DATA_WIDTH);

  logic [LANES-1:0][7:0] r_mem [DEPTH];
  logic [LANES-1:0][7:0] r_rdata;

  // Read returns the pre-write contents; there is no same-cycle read/write on this port.
  always_ff @(posedge clk) begin
    if (i_clken) begin
      if (i_we) begin
        for (int b = 0; b < LANES; b++) begin
          if (i_be[b]) r_mem[i_addr][b] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avl_onchip_ram.sv
// Avalon-MM pipelined on-chip RAM slave with optional clear-on-reset sequencer.
// Holds the FSM, clear counter, range check and the read valid/data pipeline.
module avl_onchip_ram
  import avl_onchip_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 5120,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic             clk,
  input logic             reset,
  avl_onchip_ram_if.slave bus
);
  localparam int unsigned           LANES    = lane_count(DATA_WIDTH);
  localparam int unsigned           IW       = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam state_e                ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_v0;
  logic                  r_inr0;
  logic                  r_rdv;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_clearing;
  logic                  w_wait;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_we;
  logic [IW-1:0]         w_addr;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_core_rdata;
  logic [DATA_WIDTH-1:0] w_s0_data;
  logic                  w_last_v;
  logic [DATA_WIDTH-1:0] w_last_d;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_wait     = reset | ~(r_state == ST_READY) | ~bus.clken;
  assign w_accept   = bus.chipselect & (bus.read | bus.write) & ~w_wait;
  assign w_in_range = ({1'b0, bus.address} < LP_DEPTH);
  assign w_wr       = w_accept & bus.write & w_in_range;
  // A combined read+write performs only the write.
  assign w_rd       = w_accept & bus.read & ~bus.write;

  assign w_we    = w_clearing | w_wr;
  assign w_addr  = w_clearing ? r_clr_addr[IW-1:0] : bus.address[IW-1:0];
  assign w_be    = w_clearing ? '1 : bus.byteenable;
  assign w_wdata = w_clearing ? '0 : bus.writedata;

  avl_onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk     (clk),
    .i_clken (bus.clken),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_core_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RST;
      r_clr_addr <= '0;
    end else if (bus.clken) begin
      unique case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LP_LAST) r_state <= ST_READY;
        end
        ST_READY: r_state <= ST_READY;
        default:  r_state <= ST_RST;
      endcase
    end
  end

  // Stage 0 tracks the read issued into the RAM alongside its range check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v0   <= 1'b0;
      r_inr0 <= 1'b0;
    end else if (bus.clken) begin
      r_v0   <= w_rd;
      r_inr0 <= w_in_range;
    end
  end

  assign w_s0_data = r_inr0 ? w_core_rdata : '0;

  if (READ_LATENCY == RD_LAT_TWO) begin : g_lat2
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_v1 <= 1'b0;
        r_d1 <= '0;
      end else if (bus.clken) begin
        r_v1 <= r_v0;
        if (r_v0) r_d1 <= w_s0_data;
      end
    end

    assign w_last_v = r_v1;
    assign w_last_d = r_d1;
  end else begin : g_lat1
    assign w_last_v = r_v0;
    assign w_last_d = w_s0_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdv   <= 1'b0;
      r_rdata <= '0;
    end else if (bus.clken) begin
      r_rdv <= w_last_v;
      if (w_last_v) r_rdata <= w_last_d;
    end
  end

  // A pending strobe is held while clken is low and shown once it returns.
  assign bus.readdata      = r_rdata;
  assign bus.readdatavalid = r_rdv & bus.clken;
  assign bus.waitrequest   = w_wait;
  assign bus.clear_busy    = w_clearing;

endmodule

// File: tb/tb_avl_onchip_ram.sv
// Directed bench for avl_onchip_ram: a 16-word latency-2 clearing instance and a
// 16-word latency-1 non-clearing instance.
module tb_avl_onchip_ram;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  avl_onchip_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  avl_onchip_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  avl_onchip_ram #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (AW),
    .READ_LATENCY   (2),
    .CLEAR_ON_RESET (1)
  ) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  avl_onchip_ram #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .ADDR_WIDTH     (AW),
    .READ_LATENCY   (1),
    .CLEAR_ON_RESET (0)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic rst, input logic cs, input logic rd, input logic wr,
                     input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd,
                     input logic ce);
    @(negedge clk);
    reset           = rst;
    bus0.chipselect = cs;
    bus0.read       = rd;
    bus0.write      = wr;
    bus0.address    = addr;
    bus0.byteenable = be;
    bus0.writedata  = wd;
    bus0.clken      = ce;
    #1;
  endtask

  task automatic cyc1(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] addr,
                      input logic [31:0] wd, input logic ce);
    @(negedge clk);
    bus1.chipselect = cs;
    bus1.read       = rd;
    bus1.write      = wr;
    bus1.address    = addr;
    bus1.byteenable = 4'hF;
    bus1.writedata  = wd;
    bus1.clken      = ce;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  // Releases reset and counts cycles until dut0 stops asserting waitrequest.
  task automatic wait_clear(input string name);
    int   n = 0;
    logic stale = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (i == 0) begin
        chk({name, "_busy_start"}, bus0.clear_busy, 1);
        chk({name, "_dut1_wait"}, bus1.waitrequest, 0);
      end
      if (bus0.readdatavalid) stale = 1'b1;
      if (!bus0.waitrequest) break;
      n++;
    end
    chk({name, "_clear_cycles"}, n, DEPTH);
    chk({name, "_stale_rdv"}, stale, 0);
    chk({name, "_busy_end"}, bus0.clear_busy, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp, input string name);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, addr, '0, '0, 1'b1);
    chk({name, "_accept"}, bus0.waitrequest, 0);
    for (int j = 1; j <= 4; j++) begin
      idle();
      chk($sformatf("%s_rdv%0d", name, j), bus0.readdatavalid, (j == 3));
      if (j >= 3) chk($sformatf("%s_data%0d", name, j), bus0.readdata, exp);
    end
  endtask

  task automatic do_write(input logic rd, input logic [AW-1:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input string name);
    logic stale = 1'b0;
    cyc(1'b0, 1'b1, rd, 1'b1, addr, be, wd, 1'b1);
    chk({name, "_accept"}, bus0.waitrequest, 0);
    for (int j = 1; j <= 4; j++) begin
      idle();
      if (bus0.readdatavalid) stale = 1'b1;
    end
    chk({name, "_no_rdv"}, stale, 0);
  endtask

  // One read at sample 0 with clken low for three samples starting at 'start'.
  task automatic stall_read(input int start, input string name);
    logic ce;
    for (int j = 0; j <= 8; j++) begin
      ce = !(j >= start && j < start + 3);
      cyc(1'b0, (j == 0), (j == 0), 1'b0, 5'd1, '0, '0, ce);
      chk($sformatf("%s_wait%0d", name, j), bus0.waitrequest, !ce);
      chk($sformatf("%s_rdv%0d", name, j), bus0.readdatavalid, (j == 6));
      if (j == 6) chk({name, "_data"}, bus0.readdata, 32'h2);
    end
  endtask

  task automatic rd1(input logic [AW-1:0] addr, input logic [31:0] exp, input int stall,
                     input string name);
    logic ce;
    int   vj;
    vj = (stall != 0) ? 5 : 2;
    for (int j = 0; j <= 6; j++) begin
      ce = !(stall != 0 && j >= 2 && j < 5);
      cyc1((j == 0), (j == 0), 1'b0, addr, '0, ce);
      if (j == 0) chk({name, "_accept"}, bus1.waitrequest, 0);
      chk($sformatf("%s_rdv%0d", name, j), bus1.readdatavalid, (j == vj));
      if (j == vj) chk({name, "_data"}, bus1.readdata, exp);
    end
  endtask

  initial begin
    bus0.chipselect = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = '0;
    bus0.byteenable = '0;   bus0.writedata = '0; bus0.clken = 1'b1;
    bus1.chipselect = 1'b0; bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0;
    bus1.byteenable = '0;   bus1.writedata = '0; bus1.clken = 1'b1;

    vecs[0]  = '{1'b0, 1'b1, 5'd5,  4'hF, 32'hAABBCCDD, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5,  4'h5, 32'h11223344, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd5,  4'h0, 32'h0,        32'hAA22CC44};
    vecs[3]  = '{1'b0, 1'b1, 5'd0,  4'hF, 32'h1,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd1,  4'hF, 32'h2,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd2,  4'hF, 32'h3,        32'h0};
    vecs[6]  = '{1'b0, 1'b1, 5'd3,  4'hF, 32'h4,        32'h0};
    vecs[7]  = '{1'b1, 1'b0, 5'd2,  4'h0, 32'h0,        32'h3};
    vecs[8]  = '{1'b0, 1'b1, 5'd16, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 5'd16, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  4'h0, 32'h0,        32'h1};
    vecs[11] = '{1'b1, 1'b1, 5'd7,  4'hF, 32'h12345678, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 5'd7,  4'h0, 32'h0,        32'h12345678};
    vecs[13] = '{1'b0, 1'b1, 5'd6,  4'hA, 32'hFFFFFFFF, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 5'd6,  4'h0, 32'h0,        32'hFF00FF00};
    vecs[15] = '{1'b0, 1'b1, 5'd31, 4'hF, 32'h55555555, 32'h0};
    vecs[16] = '{1'b1, 1'b0, 5'd31, 4'h0, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 1'b0, 5'd9,  4'h0, 32'h0,        32'h0};

    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("rst_readdata", bus0.readdata, 0);
    chk("rst_rdv", bus0.readdatavalid, 0);
    chk("rst_wait", bus0.waitrequest, 1);
    chk("rst_busy", bus0.clear_busy, 1);
    chk("rst_dut1_wait", bus1.waitrequest, 1);
    chk("rst_dut1_busy", bus1.clear_busy, 0);

    wait_clear("init");
    for (int a = 0; a < DEPTH; a++) do_read(AW'(a), 32'h0, $sformatf("clr%0d", a));

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rd && !vecs[i].wr)
        do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
      else
        do_write(vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd, $sformatf("vec%0d", i));
    end

    // Four back-to-back reads of 0..3 holding 1..4.
    for (int j = 0; j <= 8; j++) begin
      cyc(1'b0, (j < 4), (j < 4), 1'b0, AW'(j), '0, '0, 1'b1);
      chk($sformatf("pipe_rdv%0d", j), bus0.readdatavalid, (j >= 3 && j <= 6));
      if (j >= 3 && j <= 6) chk($sformatf("pipe_data%0d", j), bus0.readdata, j - 2);
    end

    stall_read(1, "stall_early");
    stall_read(3, "stall_late");

    cyc1(1'b1, 1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 1'b1);
    chk("d1_wr_accept", bus1.waitrequest, 0);
    rd1(5'd3, 32'hCAFEF00D, 0, "d1_rd");
    rd1(5'd20, 32'h0, 0, "d1_oor");
    rd1(5'd3, 32'hCAFEF00D, 1, "d1_stall");

    // Reset with a read in flight.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("rst2_rdv", bus0.readdatavalid, 0);
    chk("rst2_readdata", bus0.readdata, 0);
    chk("rst2_wait", bus0.waitrequest, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    wait_clear("rst2");
    do_write(1'b0, 5'd5, 4'hF, 32'h0BADF00D, "prefill5");

    // Reset again once the clear counter has reached 7.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 7; i++) idle();
    chk("mid_busy", bus0.clear_busy, 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    wait_clear("rst3");
    do_read(5'd5, 32'h0, "rst3_rd5");
    do_read(5'd2, 32'h0, "rst3_rd2");
    do_read(5'd15, 32'h0, "rst3_rd15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
